// File: rtl/reg_dump_if.sv
// Word stream from reg_dump_reader to a trace/UART dumper: one register value per
// handshake, tagged with its register index.
interface reg_dump_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks the register file's second read port on a start pulse and streams every
// register value, with its index, over a valid/ready word interface.
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int SKIP_X0  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  reg_dump_if.master        dump
);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = (SKIP_X0 != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p1;
  logic [ADDR_W-1:0] index_p1;
  logic              last_p1;
  logic              vld_p1;
  logic              hs;

  assign hs = vld_p1 & dump.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    state_d = HOLD;
      HOLD:    if (hs) state_d = last_p1 ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: walk address, presented straight to the register file read port
  // Stage p1: captured word held until the downstream handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_p0  <= '0;
      data_p1  <= '0;
      index_p1 <= '0;
      last_p1  <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) addr_p0 <= FIRST_ADDR;
        end
        READ: begin
          data_p1  <= rf_data;
          index_p1 <= addr_p0;
          last_p1  <= (addr_p0 == LAST_ADDR);
          vld_p1   <= 1'b1;
        end
        HOLD: begin
          if (hs) begin
            vld_p1 <= 1'b0;
            // Terminal compare happens before the increment, so addr never wraps.
            if (!last_p1) addr_p0 <= addr_p0 + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rf_addr        = addr_p0;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign dump.out_valid = vld_p1;
  assign dump.out_data  = data_p1;
  assign dump.out_index = index_p1;
  assign dump.out_last  = last_p1;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: two instances (x0 included / x0 skipped) reading a shared
// register-file model, checked every cycle against a word-sequence reference model.
module tb_reg_dump_reader;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in [2];
  logic        rdy_in   [2];
  int          rmode    [2];
  int          pin      [2];
  logic [31:0] mem      [N];

  logic        vld [2];
  logic        lst [2];
  logic        bsy [2];
  logic        dn  [2];
  logic [31:0] dat [2];
  logic [4:0]  idx [2];
  logic [4:0]  ra  [2];

  reg_dump_if #(.ADDR_W(5), .DATA_W(32)) if0 ();
  reg_dump_if #(.ADDR_W(5), .DATA_W(32)) if1 ();

  reg_dump_reader #(.NUM_REGS(N), .ADDR_W(5), .DATA_W(32), .SKIP_X0(0)) dut0 (
    .clk(clk), .rst(rst), .start(start_in[0]), .busy(bsy[0]), .done(dn[0]),
    .rf_addr(ra[0]), .rf_data(mem[ra[0]]), .dump(if0)
  );

  reg_dump_reader #(.NUM_REGS(N), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_in[1]), .busy(bsy[1]), .done(dn[1]),
    .rf_addr(ra[1]), .rf_data(mem[ra[1]]), .dump(if1)
  );

  assign if0.out_ready = rdy_in[0];
  assign if1.out_ready = rdy_in[1];
  assign vld[0] = if0.out_valid;
  assign vld[1] = if1.out_valid;
  assign lst[0] = if0.out_last;
  assign lst[1] = if1.out_last;
  assign dat[0] = if0.out_data;
  assign dat[1] = if1.out_data;
  assign idx[0] = if0.out_index;
  assign idx[1] = if1.out_index;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: where each dump is in its word sequence.
  logic        started = 1'b0;
  logic        m_active   [2] = '{1'b0, 1'b0};
  logic        m_done_due [2] = '{1'b0, 1'b0};
  int          m_gap      [2] = '{0, 0};
  int          m_idx      [2] = '{0, 0};
  logic        after_rst  [2] = '{1'b0, 1'b0};
  logic        p_stall    [2] = '{1'b0, 1'b0};
  logic [31:0] p_dat      [2];
  logic [4:0]  p_idx      [2];
  logic        p_lst      [2];
  logic [31:0] cap        [2][N];
  int          cap_cnt    [2] = '{0, 0};
  int          cap_fidx   [2];
  int          cap_lidx   [2];

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got 0x%08h expected 0x%08h at %0t", d, name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int d);
    logic ev;
    if (after_rst[d]) begin
      chk("rst_valid", d, 32'(vld[d]), 32'd0);
      chk("rst_data", d, dat[d], 32'd0);
      chk("rst_index", d, 32'(idx[d]), 32'd0);
      chk("rst_last", d, 32'(lst[d]), 32'd0);
      chk("rst_rf_addr", d, 32'(ra[d]), 32'd0);
      after_rst[d] = 1'b0;
    end
    ev = m_active[d] && !m_done_due[d] && (m_gap[d] == 0);
    chk("valid", d, 32'(vld[d]), 32'(ev));
    chk("busy", d, 32'(bsy[d]), 32'(m_active[d]));
    chk("done", d, 32'(dn[d]), 32'(m_done_due[d]));
    if (ev) begin
      chk("index", d, 32'(idx[d]), 32'(m_idx[d]));
      chk("data", d, dat[d], mem[m_idx[d]]);
      chk("last", d, 32'(lst[d]), 32'(m_idx[d] == N - 1));
    end
    if (p_stall[d] && !rst) begin
      chk("stall_data", d, dat[d], p_dat[d]);
      chk("stall_index", d, 32'(idx[d]), 32'(p_idx[d]));
      chk("stall_last", d, 32'(lst[d]), 32'(p_lst[d]));
    end
    if (m_done_due[d]) begin
      chk("word_count", d, 32'(cap_cnt[d]), 32'(N - d));
      if (pin[d] == 1) begin
        chk("pin_x0", d, cap[d][0], 32'd0);
        chk("pin_x1", d, cap[d][1], 32'd103);
        chk("pin_x15", d, cap[d][15], 32'd145);
        chk("pin_x31", d, cap[d][31], 32'd193);
        chk("pin_last_idx", d, 32'(cap_lidx[d]), 32'd31);
      end
      if (pin[d] == 3) begin
        chk("pin_first_idx", d, 32'(cap_fidx[d]), 32'd1);
        chk("pin_first_data", d, cap[d][1], 32'd103);
        chk("pin_last_idx", d, 32'(cap_lidx[d]), 32'd31);
        chk("pin_count", d, 32'(cap_cnt[d]), 32'd31);
      end
      if (pin[d] == 6) begin
        chk("pin_x7", d, cap[d][7], 32'hDEADBEEF);
        chk("pin_x0", d, cap[d][0], 32'd0);
      end
    end
    p_stall[d] = vld[d] && !rdy_in[d];
    p_dat[d]   = dat[d];
    p_idx[d]   = idx[d];
    p_lst[d]   = lst[d];
    if (rst) begin
      m_active[d]   = 1'b0;
      m_done_due[d] = 1'b0;
      m_gap[d]      = 0;
      after_rst[d]  = 1'b1;
      p_stall[d]    = 1'b0;
    end else if (!m_active[d]) begin
      if (start_in[d]) begin
        m_active[d] = 1'b1;
        m_idx[d]    = d;
        m_gap[d]    = 1;
        cap_cnt[d]  = 0;
      end
    end else if (m_done_due[d]) begin
      m_active[d]   = 1'b0;
      m_done_due[d] = 1'b0;
    end else if (m_gap[d] > 0) begin
      m_gap[d]--;
    end else if (rdy_in[d]) begin
      cap[d][m_idx[d]] = dat[d];
      if (cap_cnt[d] == 0) cap_fidx[d] = int'(idx[d]);
      cap_lidx[d] = int'(idx[d]);
      cap_cnt[d]++;
      if (m_idx[d] == N - 1) m_done_due[d] = 1'b1;
      else begin
        m_idx[d]++;
        m_gap[d] = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) started = 1'b1;
    if (started) begin
      check_dut(0);
      check_dut(1);
    end
  end

  // Downstream ready pattern per instance: always, 1-of-3, random, never.
  initial begin
    int cyc = 0;
    rdy_in[0] = 1'b0;
    rdy_in[1] = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      for (int d = 0; d < 2; d++) begin
        case (rmode[d])
          0:       rdy_in[d] = 1'b1;
          1:       rdy_in[d] = (cyc % 3 == 0);
          2:       rdy_in[d] = ($urandom_range(0, 3) != 0);
          default: rdy_in[d] = 1'b0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d);
    tick();
    start_in[d] = 1'b1;
    tick();
    start_in[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        $display("FAIL dut%0d timeout waiting for done: got no pulse required one", d);
        $fatal(1, "bound expired");
      end
    end while (dn[d] !== 1'b1);
    tick();
  endtask

  task automatic wait_word(input int d, input int i, input logic need_hs);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        $display("FAIL dut%0d timeout waiting for index %0d: got none required one", d, i);
        $fatal(1, "bound expired");
      end
    end while (!(vld[d] === 1'b1 && int'(idx[d]) == i && (!need_hs || rdy_in[d] === 1'b1)));
  endtask

  task automatic dump(input int d);
    pulse_start(d);
    wait_done(d);
  endtask

  initial begin
    rst = 1'b1;
    start_in[0] = 1'b0;
    start_in[1] = 1'b0;
    rmode[0] = 0;
    rmode[1] = 0;
    pin[0] = 0;
    pin[1] = 0;
    for (int i = 0; i < N; i++) mem[i] = (i == 0) ? 32'd0 : 32'(i * 3 + 100);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Full dump with ready held high, then with a 1-of-3 ready
    pin[0] = 1;
    dump(0);
    pin[0] = 0;
    rmode[0] = 1;
    dump(0);

    // x0 skipped
    pin[1] = 3;
    dump(1);
    pin[1] = 0;

    // Start re-pulsed mid-dump and on the DONE cycle
    rmode[0] = 0;
    pulse_start(0);
    wait_word(0, 5, 1'b0);
    pulse_start(0);
    wait_word(0, 20, 1'b0);
    pulse_start(0);
    wait_word(0, 31, 1'b1);
    tick();
    start_in[0] = 1'b1;
    tick();
    start_in[0] = 1'b0;
    repeat (4) tick();

    // Reset while stalled at index 10, then a fresh full dump
    pulse_start(0);
    wait_word(0, 9, 1'b1);
    tick();
    rmode[0] = 3;
    wait_word(0, 10, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rmode[0] = 1;
    tick();
    dump(0);

    // Register written before the dump
    mem[7] = 32'hDEADBEEF;
    pin[0] = 6;
    rmode[0] = 2;
    dump(0);
    pin[0] = 0;

    // Randomized contents, ready patterns and overlapping dumps on both instances
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) mem[$urandom_range(1, N - 1)] = $urandom;
      rmode[0] = $urandom_range(0, 2);
      rmode[1] = $urandom_range(0, 2);
      fork
        dump(0);
        begin
          repeat ($urandom_range(0, 5)) tick();
          dump(1);
        end
      join
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
